// File: rtl/led_pkg.sv
// Shared definitions for the LED fade/PWM block.
// Holds the colour code constants, the colour-to-RGB table and the default
// channel resolution.
package led_pkg;

   localparam int unsigned PWM_BITS_DEF = 8;
   localparam int unsigned COLOUR_W     = 3;

   // Colour codes produced by the upstream lights stage
   typedef enum logic [COLOUR_W-1:0] {
      COL_BLACK   = 3'b000,
      COL_BLUE    = 3'b001,
      COL_GREEN   = 3'b010,
      COL_CYAN    = 3'b011,
      COL_RED     = 3'b100,
      COL_MAGENTA = 3'b101,
      COL_YELLOW  = 3'b110,
      COL_WHITE   = 3'b111
   } colour_e;

   // Per-channel on/off flags for one colour
   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   // Indexed by colour code
   localparam rgb_t COLOUR_RGB [8] = '{
      rgb_t'(3'(COL_BLACK)),
      rgb_t'(3'(COL_BLUE)),
      rgb_t'(3'(COL_GREEN)),
      rgb_t'(3'(COL_CYAN)),
      rgb_t'(3'(COL_RED)),
      rgb_t'(3'(COL_MAGENTA)),
      rgb_t'(3'(COL_YELLOW)),
      rgb_t'(3'(COL_WHITE))
   };

endpackage

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: target register, level stepper, duty shadow and PWM
// comparator.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   set              channel bit of the current colour
//   tick             fade step strobe from the shared prescaler
//   pwm_max, pwm_cnt shared PWM counter and its end-of-period flag
//   enable           gates the registered pwm output
//   level            current faded level
//   pwm              registered PWM drive
//   diff_c           combinational level != target
module pwm_channel #(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set,
   input  logic                tick,
   input  logic                pwm_max,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                enable,
   output logic [PWM_BITS-1:0] level,
   output logic                pwm,
   output logic                diff_c
);

   logic [PWM_BITS-1:0] target;
   logic [PWM_BITS-1:0] duty;

   // Target follows colour every clock; level walks one step per tick
   always_ff @(posedge clk) begin
      if (rst) begin
         target <= '0;
         level  <= '0;
      end else begin
         target <= {PWM_BITS{set}};
         if (tick) begin
            if (level < target) begin
               level <= level + PWM_BITS'(1);
            end else if (level > target) begin
               level <= level - PWM_BITS'(1);
            end
         end
      end
   end

   // Duty only reloads at the last count so a period is never torn; the
   // non-blocking read picks up the pre-tick level on a coincident tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty <= '0;
         pwm  <= 1'b0;
      end else begin
         if (pwm_max) begin
            duty <= level;
         end
         pwm <= (duty > pwm_cnt) && enable;
      end
   end

   assign diff_c = (level != target);

endmodule

// File: rtl/led_fade_pwm.sv
// RGB LED driver: fades each channel toward the requested colour one step per
// prescaler tick and drives it with a PWM period of 2^PWM_BITS-1 clocks.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   colour[2:0]               requested colour (bit2=R, bit1=G, bit0=B)
//   enable                    1 = drive LEDs, 0 = force PWM outputs low
//   pwm_r, pwm_g, pwm_b       registered PWM drive
//   level_r, level_g, level_b current faded levels
//   busy                      registered, high while any level != target
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS = PWM_BITS_DEF,
   parameter int unsigned FADE_DIV = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                enable,
   output logic                pwm_r,
   output logic                pwm_g,
   output logic                pwm_b,
   output logic [PWM_BITS-1:0] level_r,
   output logic [PWM_BITS-1:0] level_g,
   output logic [PWM_BITS-1:0] level_b,
   output logic                busy
);

   localparam int unsigned         PRESC_W     = 16;
   localparam logic [PRESC_W-1:0]  PRESC_MAX   = PRESC_W'(FADE_DIV - 1);
   // Counter stops one short of all-ones so all-ones duty means always on
   localparam logic [PWM_BITS-1:0] PWM_CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

   logic [PRESC_W-1:0]  presc;
   logic                tick_c;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                pwm_max_c;
   rgb_t                rgb_c;
   logic                diff_r_c;
   logic                diff_g_c;
   logic                diff_b_c;

   assign tick_c    = (presc == PRESC_MAX);
   assign pwm_max_c = (pwm_cnt == PWM_CNT_MAX);
   assign rgb_c     = COLOUR_RGB[colour];

   // Fade prescaler
   always_ff @(posedge clk) begin
      if (rst || tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   // Shared PWM period counter
   always_ff @(posedge clk) begin
      if (rst || pwm_max_c) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Busy flag
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
      end else begin
         busy <= diff_r_c || diff_g_c || diff_b_c;
      end
   end

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
      .clk     (clk),
      .rst     (rst),
      .set     (rgb_c.r),
      .tick    (tick_c),
      .pwm_max (pwm_max_c),
      .pwm_cnt (pwm_cnt),
      .enable  (enable),
      .level   (level_r),
      .pwm     (pwm_r),
      .diff_c  (diff_r_c)
   );

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
      .clk     (clk),
      .rst     (rst),
      .set     (rgb_c.g),
      .tick    (tick_c),
      .pwm_max (pwm_max_c),
      .pwm_cnt (pwm_cnt),
      .enable  (enable),
      .level   (level_g),
      .pwm     (pwm_g),
      .diff_c  (diff_g_c)
   );

   pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
      .clk     (clk),
      .rst     (rst),
      .set     (rgb_c.b),
      .tick    (tick_c),
      .pwm_max (pwm_max_c),
      .pwm_cnt (pwm_cnt),
      .enable  (enable),
      .level   (level_b),
      .pwm     (pwm_b),
      .diff_c  (diff_b_c)
   );

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm. A fast instance (FADE_DIV=2) is
// compared cycle by cycle against a behavioural level/busy model through a
// scoreboard queue; a slow instance (FADE_DIV=300) holds a level long enough
// to measure whole PWM periods.
module tb_led_fade_pwm;

   localparam int FADE_DIV = 2;
   localparam int HOLD_DIV = 300;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] colour;
   logic       enable;
   logic       pwm_r, pwm_g, pwm_b;
   logic [7:0] level_r, level_g, level_b;
   logic       busy;

   logic       rst_h = 1'b1;
   logic [2:0] colour_h = 3'b010;
   logic       enable_h = 1'b1;
   logic       pwm_r_h, pwm_g_h, pwm_b_h;
   logic [7:0] level_r_h, level_g_h, level_b_h;
   logic       busy_h;

   always #5 clk = ~clk;

   led_fade_pwm #(.PWM_BITS(8), .FADE_DIV(FADE_DIV)) u_dut (
      .clk(clk), .rst(rst), .colour(colour), .enable(enable),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
      .level_r(level_r), .level_g(level_g), .level_b(level_b),
      .busy(busy)
   );

   led_fade_pwm #(.PWM_BITS(8), .FADE_DIV(HOLD_DIV)) u_hold (
      .clk(clk), .rst(rst_h), .colour(colour_h), .enable(enable_h),
      .pwm_r(pwm_r_h), .pwm_g(pwm_g_h), .pwm_b(pwm_b_h),
      .level_r(level_r_h), .level_g(level_g_h), .level_b(level_b_h),
      .busy(busy_h)
   );

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       busy;
   } exp_t;

   exp_t sb_q[$];
   int   hold_q[$];
   int   checks = 0;
   int   errors = 0;

   // Behavioural model state of the fast instance
   int   m_lv[3] = '{0, 0, 0};
   int   m_tg[3] = '{0, 0, 0};
   int   m_ps = 0;
   logic m_busy = 1'b0;

   function automatic string show(exp_t x);
      return $sformatf("r=%0d g=%0d b=%0d busy=%0b", x.r, x.g, x.b, x.busy);
   endfunction

   // Advance the model by one clock, queue its prediction, then clock the DUT
   task automatic cycle();
      bit tk;
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            m_lv[c] = 0;
            m_tg[c] = 0;
         end
         m_ps   = 0;
         m_busy = 1'b0;
      end else begin
         tk     = (m_ps == FADE_DIV - 1);
         m_busy = (m_lv[0] != m_tg[0]) || (m_lv[1] != m_tg[1]) || (m_lv[2] != m_tg[2]);
         for (int c = 0; c < 3; c++) begin
            if (tk && m_lv[c] < m_tg[c]) m_lv[c] = m_lv[c] + 1;
            else if (tk && m_lv[c] > m_tg[c]) m_lv[c] = m_lv[c] - 1;
         end
         m_ps    = tk ? 0 : m_ps + 1;
         m_tg[0] = colour[2] ? 255 : 0;
         m_tg[1] = colour[1] ? 255 : 0;
         m_tg[2] = colour[0] ? 255 : 0;
      end
      sb_q.push_back({8'(m_lv[0]), 8'(m_lv[1]), 8'(m_lv[2]), m_busy});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, got;
      rst = 1'b1; colour = 3'b111; enable = 1'b1;
      repeat (3) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL reset_levels: got %s need %s", show(got), show(e)); end
      end
      checks++;
      if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
         errors++; $display("FAIL reset_pwm: got %b need 000", {pwm_r, pwm_g, pwm_b});
      end
   endtask

   task automatic test_fade_blue();
      exp_t e, got;
      rst = 1'b0; colour = 3'b001; enable = 1'b1;
      for (int n = 1; n <= 1100; n++) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL fade_blue n=%0d: got %s need %s", n, show(got), show(e)); end
         checks++;
         if ({pwm_r, pwm_g} !== 2'b00) begin errors++; $display("FAIL fade_blue_rg n=%0d: got %b need 00", n, {pwm_r, pwm_g}); end
         if (n == 509) begin
            checks++;
            if (level_b !== 8'd254) begin errors++; $display("FAIL blue_509: got %0d need 254", level_b); end
         end
         if (n == 510) begin
            checks++;
            if (level_b !== 8'd255 || busy !== 1'b1) begin errors++; $display("FAIL blue_510: got b=%0d busy=%b need 255/1", level_b, busy); end
         end
         if (n == 511) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL blue_busy_fall: got %b need 0", busy); end
         end
         if (n == 765) begin
            checks++;
            if (pwm_b !== 1'b0) begin errors++; $display("FAIL blue_pre_tick_duty: got %b need 0", pwm_b); end
         end
         if (n >= 766) begin
            checks++;
            if (pwm_b !== 1'b1) begin errors++; $display("FAIL blue_full_on n=%0d: got %b need 1", n, pwm_b); end
         end
      end
   endtask

   task automatic test_cross_fade();
      exp_t e, got;
      colour = 3'b100;
      repeat (600) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL to_red: got %s need %s", show(got), show(e)); end
      end
      colour = 3'b001;
      repeat (600) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL cross: got %s need %s", show(got), show(e)); end
         checks++;
         if (int'(level_r) + int'(level_b) != 255) begin
            errors++; $display("FAIL cross_sum: got %0d need 255", int'(level_r) + int'(level_b));
         end
      end
      checks++;
      if (level_r !== 8'd0 || level_b !== 8'd255) begin
         errors++; $display("FAIL cross_end: got r=%0d b=%0d need 0/255", level_r, level_b);
      end
   endtask

   task automatic test_turnaround();
      exp_t e, got;
      bit   found;
      int   prev;
      colour = 3'b111;
      found  = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL white_up: got %s need %s", show(got), show(e)); end
         if (level_r == 8'd100) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL white_reach_100: got r=%0d need 100 within 1000 cycles", level_r); end
      colour = 3'b000;
      prev   = 100;
      repeat (700) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL black_down: got %s need %s", show(got), show(e)); end
         checks++;
         if (int'(level_r) > prev || prev - int'(level_r) > 1) begin
            errors++; $display("FAIL turnaround_jump: got %0d after %0d need step of 0 or -1", level_r, prev);
         end
         prev = int'(level_r);
      end
      checks++;
      if ({level_r, level_g, level_b} !== 24'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL black_end: got %s need all zero, busy 0", show({level_r, level_g, level_b, busy}));
      end
   endtask

   task automatic test_enable();
      exp_t e, got;
      bit   seen;
      int   lv_at_off;
      colour = 3'b111; enable = 1'b1; seen = 1'b0;
      repeat (600) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL en_up: got %s need %s", show(got), show(e)); end
         if (pwm_r) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL en_active: got pwm_r never high need some high"); end
      colour = 3'b000;
      repeat (50) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL en_fade: got %s need %s", show(got), show(e)); end
      end
      enable    = 1'b0;
      lv_at_off = int'(level_r);
      repeat (300) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL en_off_levels: got %s need %s", show(got), show(e)); end
         checks++;
         if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin errors++; $display("FAIL en_off_pwm: got %b need 000", {pwm_r, pwm_g, pwm_b}); end
      end
      checks++;
      if (int'(level_r) >= lv_at_off) begin errors++; $display("FAIL en_off_stepping: got %0d need below %0d", level_r, lv_at_off); end
      enable = 1'b1; seen = 1'b0;
      for (int i = 0; i < 256 && !seen; i++) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL en_on_levels: got %s need %s", show(got), show(e)); end
         if (pwm_r) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL en_restore: got pwm_r low for 256 cycles need high"); end
   endtask

   task automatic test_reset_mid();
      exp_t e, got;
      colour = 3'b111;
      repeat (40) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL pre_rst: got %s need %s", show(got), show(e)); end
      end
      rst = 1'b1;
      cycle();
      e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
      if (got !== e) begin errors++; $display("FAIL mid_rst_levels: got %s need %s", show(got), show(e)); end
      checks++;
      if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin errors++; $display("FAIL mid_rst_pwm: got %b need 000", {pwm_r, pwm_g, pwm_b}); end
      rst = 1'b0; colour = 3'b001;
      for (int n = 1; n <= 520; n++) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL restart n=%0d: got %s need %s", n, show(got), show(e)); end
         if (n == 1 || n == 2) begin
            checks++;
            if (level_b !== 8'(n - 1)) begin errors++; $display("FAIL restart_first_tick n=%0d: got %0d need %0d", n, level_b, n - 1); end
         end
      end
   endtask

   task automatic test_hold_64();
      exp_t e, got;
      int   hi, need;
      rst = 1'b1;
      rst_h = 1'b0;
      hold_q.push_back(63);
      hold_q.push_back(64);
      hold_q.push_back(65);
      hi = 0;
      for (int n = 1; n <= 19890; n++) begin
         cycle();
         e = sb_q.pop_front(); got = {level_r, level_g, level_b, busy}; checks++;
         if (got !== e) begin errors++; $display("FAIL hold_main_rst: got %s need %s", show(got), show(e)); end
         if (n >= 19126 && pwm_g_h) hi++;
         if (n == 19199) begin
            checks++;
            if (level_g_h !== 8'd63) begin errors++; $display("FAIL hold_level_63: got %0d need 63", level_g_h); end
         end
         if (n == 19200) begin
            checks++;
            if (level_g_h !== 8'd64 || busy_h !== 1'b1) begin errors++; $display("FAIL hold_level_64: got %0d busy=%b need 64/1", level_g_h, busy_h); end
         end
         if (n == 19380 || n == 19635 || n == 19890) begin
            need = hold_q.pop_front();
            checks++;
            if (hi != need) begin errors++; $display("FAIL hold_duty n=%0d: got %0d high cycles need %0d", n, hi, need); end
            hi = 0;
         end
      end
      checks++;
      if ({level_r_h, level_b_h} !== 16'd0 || {pwm_r_h, pwm_b_h} !== 2'b00) begin
         errors++; $display("FAIL hold_rb_off: got r=%0d b=%0d pwm=%b need 0/0/00", level_r_h, level_b_h, {pwm_r_h, pwm_b_h});
      end
   endtask

   initial begin
      test_reset();
      test_fade_blue();
      test_cross_fade();
      test_turnaround();
      test_enable();
      test_reset_mid();
      test_hold_64();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no completion need finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
